// File: rtl/axi4_wr_slave_sram.sv
// AXI4 write-only slave terminating INCR write bursts into a single-port SRAM.
// One outstanding burst; the SRAM write port is registered one cycle behind the W beat.
module axi4_wr_slave_sram #(
  parameter int                    DATA_WIDTH = 128,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_AW     = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16384
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic                    mem_we,
  output logic [MEM_AW-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    i_clr,
  output logic [15:0]             o_burst_cnt,
  output logic                    o_err,
  output logic                    o_busy
);

  localparam int                  STRB_W      = DATA_WIDTH / 8;
  localparam int                  BEAT_SH     = $clog2(STRB_W);
  localparam logic [2:0]          SIZE_OK     = 3'(BEAT_SH);
  localparam logic [1:0]          BURST_INCR  = 2'b01;
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH:0] WIN_LAST    = (ADDR_WIDTH + 1)'((1 << MEM_AW) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [7:0]              len_q, cnt_q;
  logic [MEM_AW-1:0]       ptr_q;
  logic                    bad_q, wl_err_q;
  logic                    mem_we_q;
  logic [MEM_AW-1:0]       mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [STRB_W-1:0]       mem_wstrb_q;
  logic [15:0]             burst_cnt_q, burst_cnt_d;
  logic                    err_q, err_d;

  logic                    aw_hs, w_hs, b_hs, last_beat, aw_bad;
  logic [ADDR_WIDTH-1:0]   off;
  logic [ADDR_WIDTH:0]     last_word;
  logic [1:0]              resp;

  assign aw_hs     = s_awvalid & s_awready;
  assign w_hs      = s_wvalid & s_wready;
  assign b_hs      = s_bvalid & s_bready;
  assign last_beat = (cnt_q == len_q);

  // Window check is done once at AW time; a bad burst is drained without touching the SRAM.
  assign off       = s_awaddr - BASE_ADDR;
  assign last_word = {1'b0, off >> BEAT_SH} + {{(ADDR_WIDTH - 7){1'b0}}, s_awlen};
  assign aw_bad    = (s_awburst != BURST_INCR) | (s_awsize != SIZE_OK) |
                     (s_awaddr < BASE_ADDR) | (s_awaddr[BEAT_SH-1:0] != '0) |
                     (last_word > WIN_LAST);

  assign resp      = (bad_q | wl_err_q) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (aw_hs)             state_d = S_DATA;
      S_DATA:  if (w_hs && last_beat) state_d = S_RESP;
      S_RESP:  if (s_bready)          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // awready is also held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (state_q)
      S_IDLE:  s_awready = rst_n;
      S_DATA:  s_wready  = 1'b1;
      S_RESP:  s_bvalid  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    if (i_clr) begin
      burst_cnt_d = '0;
      err_d       = 1'b0;
    end else if (b_hs) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
      if (resp == RESP_SLVERR) err_d = 1'b1;
    end
  end

  // Burst is closed by the beat count; a WLAST mismatch only poisons the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      bad_q       <= 1'b0;
      wl_err_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      if (aw_hs) begin
        id_q     <= s_awid;
        len_q    <= s_awlen;
        cnt_q    <= '0;
        ptr_q    <= off[BEAT_SH +: MEM_AW];
        bad_q    <= aw_bad;
        wl_err_q <= 1'b0;
      end
      if (w_hs) begin
        cnt_q <= cnt_q + 8'd1;
        ptr_q <= ptr_q + 1'b1;
        if (s_wlast != last_beat) wl_err_q <= 1'b1;
        if (!bad_q) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= ptr_q;
          mem_wdata_q <= s_wdata;
          mem_wstrb_q <= s_wstrb;
        end
      end
    end
  end

  assign s_bid       = id_q;
  assign s_bresp     = resp;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign o_burst_cnt = burst_cnt_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi4_wr_slave_sram.sv
// Directed + randomized bench for axi4_wr_slave_sram with a word-level memory model.
module tb_axi4_wr_slave_sram;

  localparam longint BASE = 16384;
  localparam int     NW   = 1024;

  logic         clk, rst_n;
  logic [3:0]   s_awid;
  logic [31:0]  s_awaddr;
  logic [7:0]   s_awlen;
  logic [2:0]   s_awsize;
  logic [1:0]   s_awburst;
  logic         s_awvalid, s_awready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic         s_wlast, s_wvalid, s_wready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bvalid, s_bready;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_wstrb;
  logic         i_clr;
  logic [15:0]  o_burst_cnt;
  logic         o_err, o_busy;

  axi4_wr_slave_sram dut (
    .clk(clk), .rst_n(rst_n),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .i_clr(i_clr), .o_burst_cnt(o_burst_cnt), .o_err(o_err), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // What the DUT actually wrote to the SRAM port
  int           got_cnt [NW];
  logic [127:0] got_data[NW];
  logic [15:0]  got_strb[NW];
  int           wr_total = 0;
  int           wr_cyc_q[$];
  int           wr_addr_q[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_cnt[mem_addr]  = got_cnt[mem_addr] + 1;
      got_data[mem_addr] = mem_wdata;
      got_strb[mem_addr] = mem_wstrb;
      wr_total           = wr_total + 1;
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(int'(mem_addr));
    end
  end

  // Reference model state
  int           exp_cnt [NW];
  logic [127:0] exp_data[NW];
  logic [15:0]  exp_strb[NW];
  int           m_bursts = 0;
  bit           m_err    = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_bad(input longint addr, input int len, input int size, input int burst);
    if (burst != 1) return 1'b1;
    if (size != 4) return 1'b1;
    if (addr < BASE) return 1'b1;
    if (addr % 16 != 0) return 1'b1;
    if ((addr - BASE) / 16 + len >= NW) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send_aw(input logic [3:0] id, input longint addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst, output int aw_c);
    bit ok;
    ok        = 1'b0;
    s_awid    = id;
    s_awaddr  = addr[31:0];
    s_awlen   = 8'(len);
    s_awsize  = size;
    s_awburst = burst;
    s_awvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_awready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("aw_handshake", ok, 1'b1);
    aw_c = cyc;
    chk("wready_low_in_aw_cycle", s_wready, 1'b0);
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] st, input bit last, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      s_wvalid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    s_wdata  = d;
    s_wstrb  = st;
    s_wlast  = last;
    s_wvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_wready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("w_handshake", ok, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic get_b(input int stall, output logic [1:0] resp, output logic [3:0] id, output int b_c);
    bit ok;
    logic [1:0] r0;
    ok       = 1'b0;
    s_bready = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_bvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bvalid_seen", ok, 1'b1);
    b_c = cyc;
    for (int k = 0; k < stall; k++) begin
      r0 = s_bresp;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bvalid_held", s_bvalid, 1'b1);
      chk("bresp_held", s_bresp, r0);
    end
    s_bready = 1'b1;
    resp = s_bresp;
    id   = s_bid;
    @(posedge clk);
    #1;
    s_bready = 1'b0;
  endtask

  task automatic do_burst(input logic [3:0] id, input longint addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int wl_beat,
                          input int gmax, input int smax, input bit idx_data, input bit rstrb,
                          output int aw_c, output int b_c);
    logic [127:0] d [256];
    logic [15:0]  st[256];
    logic [1:0]   resp, exp_resp;
    logic [3:0]   bid;
    bit           bad;
    int           w0, last_at, w;
    bad     = ref_bad(addr, len, int'(size), int'(burst));
    last_at = (wl_beat >= 0) ? wl_beat : len;
    w0      = wr_total;
    send_aw(id, addr, len, size, burst, aw_c);
    for (int b = 0; b <= len; b++) begin
      d[b]  = idx_data ? 128'(b) : {$urandom, $urandom, $urandom, $urandom};
      st[b] = rstrb ? 16'($urandom) : 16'hFFFF;
      send_beat(d[b], st[b], (b == last_at), (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0);
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    get_b((smax > 0) ? int'($urandom_range(smax, 0)) : 0, resp, bid, b_c);
    exp_resp = (bad || (last_at != len)) ? 2'b10 : 2'b00;
    if (!bad) begin
      for (int b = 0; b <= len; b++) begin
        w = int'((addr - BASE) / 16) + b;
        exp_cnt[w]++;
        exp_data[w] = d[b];
        exp_strb[w] = st[b];
      end
    end
    m_bursts = (m_bursts + 1) & 16'hFFFF;
    if (exp_resp == 2'b10) m_err = 1'b1;
    chk("bresp", resp, exp_resp);
    chk("bid", bid, id);
    chk("burst_writes", 32'(wr_total - w0), bad ? 32'd0 : 32'(len + 1));
    chk("burst_cnt", o_burst_cnt, 16'(m_bursts));
    chk("err_flag", o_err, m_err);
    chk("busy_after_b", o_busy, 1'b0);
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    @(posedge clk);
    #1;
    i_clr    = 1'b0;
    m_bursts = 0;
    m_err    = 1'b0;
    chk("clr_cnt", o_burst_cnt, 16'd0);
    chk("clr_err", o_err, 1'b0);
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < NW; w++) begin
      chk({tag, "_cnt"}, got_cnt[w], exp_cnt[w]);
      if (exp_cnt[w] > 0) begin
        chk({tag, "_data"}, got_data[w], exp_data[w]);
        chk({tag, "_strb"}, got_strb[w], exp_strb[w]);
      end
    end
  endtask

  initial begin
    int           aw_c, b_c, ac;
    logic [127:0] d0, d1, d2;
    longint       bad_addr [5];
    logic [2:0]   bad_size [5];
    logic [1:0]   bad_burst[5];
    int           bad_len  [5];

    for (int w = 0; w < NW; w++) begin
      got_cnt[w] = 0;
      exp_cnt[w] = 0;
    end
    rst_n = 1'b0; i_clr = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cnt", o_burst_cnt, 16'd0);
    chk("rst_err", o_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("awready_after_rst", s_awready, 1'b1);
    @(posedge clk);
    #1;

    // 8-beat burst at full throughput, data = beat index
    wr_cyc_q.delete();
    wr_addr_q.delete();
    do_burst(4'd5, BASE, 7, 3'd4, 2'b01, -1, 0, 0, 1'b1, 1'b0, aw_c, b_c);
    chk("t1_nwrites", wr_cyc_q.size(), 8);
    for (int i = 0; i < 8 && i < wr_cyc_q.size(); i++) begin
      chk("t1_addr", wr_addr_q[i], i);
      chk("t1_wr_cycle", wr_cyc_q[i], aw_c + 2 + i);
      chk("t1_data", got_data[i], 128'(i));
    end
    chk("t1_bvalid_cycle", b_c, aw_c + 9);
    chk("t1_burst_cnt", o_burst_cnt, 16'd1);
    @(negedge clk);
    chk("t1_next_aw_ready", s_awready, 1'b1);
    chk("t1_next_aw_cycle", cyc, b_c + 1);
    @(posedge clk);
    #1;

    // 128 back-to-back bursts covering the window, with gaps and stalls
    pulse_clr();
    for (int w = 0; w < NW; w++) begin
      got_cnt[w] = 0;
      exp_cnt[w] = 0;
    end
    for (int k = 0; k < 128; k++)
      do_burst(4'(k), BASE + 128 * k, 7, 3'd4, 2'b01, -1, 3, 5, 1'b0, 1'b1, aw_c, b_c);
    for (int w = 0; w < NW; w++) chk("t2_once", got_cnt[w], 1);
    check_mem("t2_mem");
    chk("t2_burst_cnt", o_burst_cnt, 16'd128);
    chk("t2_err", o_err, 1'b0);

    // Window overrun, then clear
    do_burst(4'd3, BASE + 1024 * 16 - 64, 7, 3'd4, 2'b01, -1, 1, 2, 1'b0, 1'b0, aw_c, b_c);
    chk("t3_err_set", o_err, 1'b1);
    pulse_clr();
    // Last legal burst right at the window top
    do_burst(4'd4, BASE + 1024 * 16 - 128, 7, 3'd4, 2'b01, -1, 0, 1, 1'b0, 1'b0, aw_c, b_c);

    // Rejected bursts: WRAP, wrong size, misaligned, below base, one word past the window
    bad_addr[0] = BASE + 64;        bad_size[0] = 3'd4; bad_burst[0] = 2'b10; bad_len[0] = 3;
    bad_addr[1] = BASE + 64;        bad_size[1] = 3'd3; bad_burst[1] = 2'b01; bad_len[1] = 3;
    bad_addr[2] = BASE + 8;         bad_size[2] = 3'd4; bad_burst[2] = 2'b01; bad_len[2] = 0;
    bad_addr[3] = BASE - 16;        bad_size[3] = 3'd4; bad_burst[3] = 2'b01; bad_len[3] = 0;
    bad_addr[4] = BASE + 16 * 1023; bad_size[4] = 3'd4; bad_burst[4] = 2'b01; bad_len[4] = 1;
    for (int t = 0; t < 5; t++)
      do_burst(4'(t + 8), bad_addr[t], bad_len[t], bad_size[t], bad_burst[t], -1, 1, 1,
               1'b0, 1'b0, aw_c, b_c);

    // Premature WLAST on the 4th beat: writes still land, response is SLVERR
    do_burst(4'd6, BASE + 16 * 200, 7, 3'd4, 2'b01, 3, 1, 1, 1'b0, 1'b0, aw_c, b_c);
    do_burst(4'd7, BASE + 16 * 300, 3, 3'd4, 2'b01, -1, 0, 0, 1'b0, 1'b0, aw_c, b_c);

    // Reset in the middle of a burst
    send_aw(4'd9, BASE + 16 * 500, 7, 3'd4, 2'b01, ac);
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    send_beat(d0, 16'hFFFF, 1'b0, 0);
    send_beat(d1, 16'hFFFF, 1'b0, 0);
    send_beat(d2, 16'hFFFF, 1'b0, 0);
    s_wvalid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_bvalid", s_bvalid, 1'b0);
    chk("midrst_wready", s_wready, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_cnt", o_burst_cnt, 16'd0);
    m_bursts = 0;
    m_err    = 1'b0;
    exp_cnt[500]++; exp_data[500] = d0; exp_strb[500] = 16'hFFFF;
    exp_cnt[501]++; exp_data[501] = d1; exp_strb[501] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_awready", s_awready, 1'b1);
    @(posedge clk);
    #1;
    do_burst(4'd10, BASE + 16 * 500, 7, 3'd4, 2'b01, -1, 1, 2, 1'b0, 1'b1, aw_c, b_c);
    check_mem("final_mem");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
